// File: rtl/dadder_arb_pkg.sv
// Shared types and helpers for the decimal adder request arbiter.
// Holds the FSM state encoding, datapath op codes and the round-robin step function.
package dadder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic DADDER_OP_ADD = 1'b0;
    localparam logic DADDER_OP_SUB = 1'b1;

    // Next index in a ring of num requesters, wrapping back to 0.
    function automatic int rr_next_idx(input int idx, input int num);
        return ((idx + 32'sd1) >= num) ? 32'sd0 : (idx + 32'sd1);
    endfunction

endpackage

// File: rtl/dadder_rr_arb.sv
// Combinational round-robin selector: searches req starting one past rr_ptr
// and returns the first hit as a one-hot grant plus its index.
module dadder_rr_arb
    import dadder_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_valid
);

    logic          found_s;
    logic [IW-1:0] idx_s;
    logic          hit_s;
    int            cand_s;

    // Walk the ring once from rr_ptr+1; the first requesting slot wins.
    always_comb begin
        found_s = 1'b0;
        idx_s   = {IW{1'b0}};
        hit_s   = 1'b0;
        cand_s  = rr_next_idx(int'(rr_ptr), N);
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                hit_s   = !found_s && (i == cand_s) && req[i];
                idx_s   = hit_s ? IW'(i) : idx_s;
                found_s = found_s | hit_s;
            end
            cand_s = rr_next_idx(cand_s, N);
        end
    end

    assign grant     = found_s ? ({{(N-1){1'b0}}, 1'b1} << idx_s) : {N{1'b0}};
    assign grant_idx = idx_s;
    assign any_valid = found_s;

endmodule

// File: rtl/dadder_req_arb.sv
// Round-robin front end sharing one decimal add/sub datapath among NUM_REQ clients.
// Optional WAIT watchdog and err_timeout port: define DADDER_REQ_ARB_TIMEOUT_EN.
module dadder_req_arb
    import dadder_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_DIGITS = 8,
    parameter int TIMEOUT    = 64,
    localparam int W  = 4 * NUM_DIGITS,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_op,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_result,
    output logic                 rsp_carry,
    output logic                 dad_in_valid,
    input  logic                 dad_in_ready,
    output logic                 dad_op,
    output logic [W-1:0]         dad_a,
    output logic [W-1:0]         dad_b,
    input  logic                 dad_out_valid,
    input  logic [W-1:0]         dad_result,
    input  logic                 dad_carry,
    output logic                 busy,
    output logic [IW-1:0]        grant_idx,
    output logic                 err_unexp
`ifdef DADDER_REQ_ARB_TIMEOUT_EN
    ,
    output logic                 err_timeout
`endif
);

    // Refuse configurations the ring search and watchdog were not sized for.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("dadder_req_arb: unsupported NUM_REQ or TIMEOUT");
    end

    arb_state_e           state_r, state_nx_s;
    logic [IW-1:0]        rr_ptr_r;
    logic [IW-1:0]        grant_idx_r;
    logic                 op_r;
    logic [W-1:0]         a_r, b_r;
    logic [W-1:0]         result_r;
    logic                 carry_r;
    logic                 dad_in_valid_r;
    logic                 busy_r;
    logic [NUM_REQ-1:0]   rsp_valid_r;
    logic                 err_unexp_r;

    logic [NUM_REQ-1:0]   arb_grant_s;
    logic [IW-1:0]        arb_idx_s;
    logic                 arb_any_s;
    logic                 accept_s;
    logic                 capture_s;
    logic                 timeout_s;
    logic                 rsp_done_s;

    dadder_rr_arb #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .any_valid (arb_any_s)
    );

`ifdef DADDER_REQ_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_r;
    logic          err_timeout_r;
    logic          wait_expired_s;

    assign wait_expired_s = (wait_cnt_r == CW'(TIMEOUT - 1));

    // WAIT watchdog: restarts on WAIT entry, counts every cycle spent in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r    <= {CW{1'b0}};
            err_timeout_r <= 1'b0;
        end else begin
            err_timeout_r <= timeout_s;
            if (state_nx_s == WAIT && state_r != WAIT) begin
                wait_cnt_r <= {CW{1'b0}};
            end else if (state_r == WAIT) begin
                wait_cnt_r <= wait_cnt_r + 1'b1;
            end
        end
    end

    assign err_timeout = err_timeout_r;
`else
    logic wait_expired_s;
    assign wait_expired_s = 1'b0;
`endif

    // Next-state decode and the single-cycle strobes that move data between planes.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        capture_s  = 1'b0;
        timeout_s  = 1'b0;
        rsp_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_any_s) begin
                    accept_s   = 1'b1;
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (dad_in_ready) begin
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = ISSUE;
                end
            end
            WAIT: begin
                if (dad_out_valid) begin
                    capture_s  = 1'b1;
                    state_nx_s = RESP;
                end else if (wait_expired_s) begin
                    timeout_s  = 1'b1;
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready[grant_idx_r]) begin
                    rsp_done_s = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, operand/result capture and registered output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            rr_ptr_r       <= IW'(NUM_REQ - 1);
            grant_idx_r    <= {IW{1'b0}};
            op_r           <= DADDER_OP_ADD;
            a_r            <= {W{1'b0}};
            b_r            <= {W{1'b0}};
            result_r       <= {W{1'b0}};
            carry_r        <= 1'b0;
            dad_in_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            rsp_valid_r    <= {NUM_REQ{1'b0}};
            err_unexp_r    <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            dad_in_valid_r <= (state_nx_s == ISSUE);
            busy_r         <= (state_nx_s != IDLE);
            rsp_valid_r    <= (state_nx_s == RESP)
                              ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_r)
                              : {NUM_REQ{1'b0}};
            // A result is only legal once the operands have left ISSUE.
            err_unexp_r    <= dad_out_valid && (state_r != WAIT);
            if (accept_s) begin
                grant_idx_r <= arb_idx_s;
                op_r        <= req_op[arb_idx_s];
                a_r         <= req_a[arb_idx_s*W +: W];
                b_r         <= req_b[arb_idx_s*W +: W];
            end
            if (capture_s) begin
                result_r <= dad_result;
                carry_r  <= dad_carry;
            end else if (timeout_s) begin
                result_r <= {W{1'b0}};
                carry_r  <= 1'b0;
            end
            if (rsp_done_s) begin
                rr_ptr_r <= grant_idx_r;
            end
        end
    end

    assign req_ready    = (state_r == IDLE) ? arb_grant_s : {NUM_REQ{1'b0}};
    assign rsp_valid    = rsp_valid_r;
    assign rsp_result   = result_r;
    assign rsp_carry    = carry_r;
    assign dad_in_valid = dad_in_valid_r;
    assign dad_op       = op_r;
    assign dad_a        = a_r;
    assign dad_b        = b_r;
    assign busy         = busy_r;
    assign grant_idx    = grant_idx_r;
    assign err_unexp    = err_unexp_r;

endmodule
